hazard_detection_unit: RTL and testbench
========================================

Name: hazard_detection_unit

Overview:
- Load-use hazard detector for the 5-stage pipelined CPU, placed in the ID stage.
- Compares the destination register of a load in ID/EX against both source registers of the instruction in IF/ID.
- On a match it deasserts wr_enable, freezing PC and IF/ID, and asserts bubble to zero the ID/EX control word.
- Also keeps registered stall bookkeeping (previous-cycle stall flag, saturating stall counter) for performance monitoring.

Parameters:
- REG_AW, 4, register-address width (16 architectural registers).
- CNT_W, 16, width of the stall event counter.
- ZERO_REG_EXEMPT, 0, when 1 a match on register 0 never stalls; when 0 register 0 is compared like any other.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- memRead  input  1  ID/EX stage MemRead control (instruction in EX is a load).
- r2IDEX  input  REG_AW  load destination register held in ID/EX.
- r1IFID  input  REG_AW  first source register of the instruction in IF/ID.
- r2IFID  input  REG_AW  second source register of the instruction in IF/ID.
- wr_enable  output  1  1 = PC and IF/ID may update; 0 = stall.
- bubble  output  1  1 = force ID/EX control signals to zero this cycle.
- stall_q  output  1  registered: a stall was signalled in the previous cycle.
- stall_count  output  CNT_W  registered count of stall cycles since reset.

Behaviour:
- hazard = memRead & ((r2IDEX == r1IFID) | (r2IDEX == r2IFID)).
- When ZERO_REG_EXEMPT = 1, hazard is additionally masked to 0 when r2IDEX == 0.
- wr_enable = ~hazard; bubble = hazard. Both are purely combinational, zero latency, and valid within the same cycle as the inputs.
- wr_enable and bubble do not depend on rst; they reflect the current inputs even while rst is high.
- memRead = 0 always gives wr_enable = 1 and bubble = 0, whatever the register addresses.
- A match on either source register is sufficient; a match on both still produces a single stall.
- No forwarding awareness: the unit stalls exactly one cycle per load-use occurrence. The next cycle's inputs (the bubble now in ID/EX, with memRead = 0) release the stall naturally.
- stall_q: on each rising clk edge it loads hazard. rst = 1 at the edge clears it to 0.
- stall_count: on each rising clk edge with rst = 0 and hazard = 1 it increments by 1. It saturates at all-ones and does not wrap. rst = 1 at the edge clears it to 0; rst takes priority over an increment in the same cycle.
- Reset mid-operation: registered outputs read 0 from the first edge at which rst is sampled high. Counting resumes on the first edge with rst low.
- X/unknown inputs are not required to be handled. memRead is assumed to be a clean 0/1.

Decomposition:
- Shared cpu package: REG_AW constant (4) and a reg_addr_t typedef for register addresses. The same types are used by the register file and the forwarding unit.
- No sub-module: the combinational comparator and the small counter live in one module.

Test Plan:
- memRead=0, r2IDEX=0, r1IFID=0, r2IFID=0 -> wr_enable=1, bubble=0 (no load, so no stall despite equal addresses).
- memRead=1, r2IDEX=0, r1IFID=0, r2IFID=1 -> wr_enable=0, bubble=1. Then memRead=1, r2IDEX=0, r1IFID=1, r2IFID=1 -> wr_enable=1 (no match).
- memRead=1, r2IDEX=1, r1IFID=0, r2IFID=1 -> wr_enable=0 (match on the second source). memRead=0, r2IDEX=1, r1IFID=1, r2IFID=0 -> wr_enable=1.
- Three consecutive hazard cycles, then one clean cycle -> stall_count reaches 3. stall_q is 1 after each hazard edge and 0 after the clean edge. Assert rst for one edge while hazard is high -> stall_count=0 and stall_q=0; wr_enable is still 0 during reset.
- With CNT_W forced to 2, apply five hazard cycles -> stall_count sticks at 3 (saturates, no wrap).
- With ZERO_REG_EXEMPT=1: memRead=1, r2IDEX=0, r1IFID=0 -> wr_enable=1. With memRead=1, r2IDEX=5, r2IFID=5 -> wr_enable=0.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared CPU types: register-address width and the register-address type
// used by the register file, forwarding unit and hazard detection unit.
package hazard_detection_unit_pkg;

  localparam int unsigned REG_AW = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage : hazard_detection_unit_pkg

// File: rtl/hazard_detection_unit.sv
// Load-use hazard detector for the ID stage of the 5-stage pipeline.
// A load in ID/EX whose destination matches either source of the IF/ID
// instruction freezes PC and IF/ID (wr_enable=0) and injects a bubble.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   memRead             ID/EX instruction is a load
//   r2IDEX              load destination register in ID/EX
//   r1IFID, r2IFID      source registers of the IF/ID instruction
//   wr_enable, bubble   combinational stall controls (independent of rst)
//   stall_q             a stall was signalled in the previous cycle
//   stall_count         saturating count of stall cycles since reset
module hazard_detection_unit
  import hazard_detection_unit_pkg::*;
#(
  parameter int unsigned REG_AW          = hazard_detection_unit_pkg::REG_AW,
  parameter int unsigned CNT_W           = 16,
  parameter bit          ZERO_REG_EXEMPT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic [REG_AW-1:0] r2IDEX,
  input  logic [REG_AW-1:0] r1IFID,
  input  logic [REG_AW-1:0] r2IFID,
  output logic              wr_enable,
  output logic              bubble,
  output logic              stall_q,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             hazard;
  logic             zero_masked;
  logic             stall_d;
  logic [CNT_W-1:0] stall_count_d;
  logic [CNT_W-1:0] stall_count_q;

  // Comparator; register 0 optionally never stalls (hardwired-zero ISAs)
  always_comb begin
    zero_masked = ZERO_REG_EXEMPT && (r2IDEX == '0);
    hazard      = memRead && ((r2IDEX == r1IFID) || (r2IDEX == r2IFID))
                  && !zero_masked;
    wr_enable   = !hazard;
    bubble      = hazard;
  end

  // Next-state for stall bookkeeping; counter holds at all-ones
  always_comb begin
    stall_d       = hazard;
    stall_count_d = stall_count_q;
    if (hazard && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  // Bookkeeping registers; reset wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q       <= 1'b0;
      stall_count_q <= '0;
    end else begin
      stall_q       <= stall_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule : hazard_detection_unit

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read;
  logic [3:0] r2_idex, r1_ifid, r2_ifid;

  // Three configurations share one stimulus stream
  logic        we_def, bb_def, sq_def;
  logic [15:0] sc_def;
  logic        we_sat, bb_sat, sq_sat;
  logic [1:0]  sc_sat;
  logic        we_zre, bb_zre, sq_zre;
  logic [15:0] sc_zre;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integers, saturation via min()
  int exp_cnt_def, exp_cnt_sat, exp_cnt_zre;
  bit exp_sq_def, exp_sq_zre;

  always #5 clk = ~clk;

  hazard_detection_unit #(.REG_AW(4), .CNT_W(16), .ZERO_REG_EXEMPT(1'b0)) u_def (
    .clk(clk), .rst(rst), .memRead(mem_read), .r2IDEX(r2_idex),
    .r1IFID(r1_ifid), .r2IFID(r2_ifid), .wr_enable(we_def), .bubble(bb_def),
    .stall_q(sq_def), .stall_count(sc_def));

  hazard_detection_unit #(.REG_AW(4), .CNT_W(2), .ZERO_REG_EXEMPT(1'b0)) u_sat (
    .clk(clk), .rst(rst), .memRead(mem_read), .r2IDEX(r2_idex),
    .r1IFID(r1_ifid), .r2IFID(r2_ifid), .wr_enable(we_sat), .bubble(bb_sat),
    .stall_q(sq_sat), .stall_count(sc_sat));

  hazard_detection_unit #(.REG_AW(4), .CNT_W(16), .ZERO_REG_EXEMPT(1'b1)) u_zre (
    .clk(clk), .rst(rst), .memRead(mem_read), .r2IDEX(r2_idex),
    .r1IFID(r1_ifid), .r2IFID(r2_ifid), .wr_enable(we_zre), .bubble(bb_zre),
    .stall_q(sq_zre), .stall_count(sc_zre));

  function automatic bit model_hazard(bit exempt);
    int d, s1, s2;
    d  = int'(r2_idex);
    s1 = int'(r1_ifid);
    s2 = int'(r2_ifid);
    if (!mem_read) return 1'b0;
    if (exempt && d == 0) return 1'b0;
    return (d == s1) || (d == s2);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check combinational outputs mid-cycle, then the
  // registered outputs just after the edge against the model
  task automatic step(input bit m, input int d, input int s1, input int s2, input bit r);
    bit hz, hz_z;
    @(negedge clk);
    mem_read = m;
    r2_idex  = 4'(d);
    r1_ifid  = 4'(s1);
    r2_ifid  = 4'(s2);
    rst      = r;
    #1;
    hz   = model_hazard(1'b0);
    hz_z = model_hazard(1'b1);
    check("def_wr_enable", 16'(we_def), 16'(!hz));
    check("def_bubble",    16'(bb_def), 16'(hz));
    check("sat_wr_enable", 16'(we_sat), 16'(!hz));
    check("zre_wr_enable", 16'(we_zre), 16'(!hz_z));
    check("zre_bubble",    16'(bb_zre), 16'(hz_z));
    @(posedge clk);
    if (r) begin
      exp_cnt_def = 0; exp_cnt_sat = 0; exp_cnt_zre = 0;
      exp_sq_def  = 0; exp_sq_zre  = 0;
    end else begin
      exp_sq_def = hz;
      exp_sq_zre = hz_z;
      if (hz)   exp_cnt_def = (exp_cnt_def + 1 > 65535) ? 65535 : exp_cnt_def + 1;
      if (hz)   exp_cnt_sat = (exp_cnt_sat + 1 > 3)     ? 3     : exp_cnt_sat + 1;
      if (hz_z) exp_cnt_zre = (exp_cnt_zre + 1 > 65535) ? 65535 : exp_cnt_zre + 1;
    end
    #1;
    check("def_stall_q",     16'(sq_def), 16'(exp_sq_def));
    check("def_stall_count", sc_def,      16'(exp_cnt_def));
    check("sat_stall_q",     16'(sq_sat), 16'(exp_sq_def));
    check("sat_stall_count", 16'(sc_sat), 16'(exp_cnt_sat));
    check("zre_stall_q",     16'(sq_zre), 16'(exp_sq_zre));
    check("zre_stall_count", sc_zre,      16'(exp_cnt_zre));
  endtask

  initial begin
    mem_read = 1'b0; r2_idex = '0; r1_ifid = '0; r2_ifid = '0; rst = 1'b1;
    exp_cnt_def = 0; exp_cnt_sat = 0; exp_cnt_zre = 0;
    exp_sq_def = 0; exp_sq_zre = 0;

    // Reset state
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // No load: equal addresses do not stall
    step(0, 0, 0, 0, 0);
    // Match on first source (register 0; exempt instance must not stall)
    step(1, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    // Match on second source, then no load
    step(1, 1, 0, 1, 0);
    step(0, 1, 1, 0, 0);

    // Reset, three hazards, one clean cycle
    step(0, 0, 0, 0, 1);
    step(1, 7, 7, 3, 0);
    step(1, 7, 2, 7, 0);
    step(1, 7, 7, 7, 0);
    step(0, 7, 7, 7, 0);
    check("three_hazard_count", sc_def, 16'd3);
    // Reset while hazard is high: wr_enable still 0, registers cleared
    step(1, 5, 5, 5, 1);
    check("reset_count", sc_def, 16'd0);

    // Five hazards: 2-bit counter sticks at 3
    for (int i = 0; i < 5; i++) step(1, 9, 9, 1, 0);
    check("sat_stuck", 16'(sc_sat), 16'd3);

    // Exempt instance: register 5 still stalls, register 0 does not
    step(1, 5, 4, 5, 0);
    step(1, 0, 0, 3, 0);

    // Randomized traffic with narrow address range to hit matches often
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 24) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_detection_unit
